// File: rtl/selector_cubos_if.sv
// selector_cubos_if: control and status bundle between the game logic and the cube selector
interface selector_cubos_if #(
  parameter int NUM_CUBOS = 4,
  parameter int ANCHO = $clog2(NUM_CUBOS)
);
  logic rotar;
  logic dir;
  logic [NUM_CUBOS-1:0] habilitados;
  logic cargar;
  logic [ANCHO-1:0] valor_carga;
  logic auto_en;
  logic [ANCHO-1:0] indice;
  logic [NUM_CUBOS-1:0] activaciones_cubos;
  logic vuelta;
  logic ninguno;
  modport master (
    output rotar, dir, habilitados, cargar, valor_carga, auto_en,
    input indice, activaciones_cubos, vuelta, ninguno
  );
  modport slave (
    input rotar, dir, habilitados, cargar, valor_carga, auto_en,
    output indice, activaciones_cubos, vuelta, ninguno
  );
endinterface

// File: rtl/selector_cubos.sv
// selector_cubos: active cube selector with masked stepping, load and optional auto-rotation (SELECTOR_CUBOS_AUTO_EN)
module selector_cubos #(
  parameter int NUM_CUBOS = 4,
  parameter int ANCHO = $clog2(NUM_CUBOS),
  parameter int PERIODO = 50_000_000
) (
  input logic clk,
  input logic reset,
  selector_cubos_if.slave bus
);
  logic tick;
  logic paso;
  logic carga_ok;
  logic cruce;
  logic [ANCHO-1:0] destino;
  logic [ANCHO-1:0] siguiente;
  logic [2*NUM_CUBOS-1:0] giro;
`ifdef SELECTOR_CUBOS_AUTO_EN
  localparam int TW = $clog2(PERIODO);
  logic [TW-1:0] cuenta;
  assign tick = bus.auto_en && cuenta == TW'(PERIODO - 1);
  always_ff @(posedge clk)
    if (reset || bus.cargar || bus.rotar || !bus.auto_en || tick) cuenta <= '0;
    else cuenta <= cuenta + 1'b1;
`else
  logic unused_auto;
  assign unused_auto = bus.auto_en ^ (PERIODO > 1);
  assign tick = 1'b0;
`endif
  assign paso = bus.rotar | tick;
  assign carga_ok = int'(bus.valor_carga) < NUM_CUBOS;
  // bit j of giro is the enable of cube (indice + j) mod NUM_CUBOS
  assign giro = {bus.habilitados, bus.habilitados} >> bus.indice;
  always_comb begin
    destino = bus.indice;
    for (int i = NUM_CUBOS; i >= 1; i--)
      if (bus.dir ? giro[NUM_CUBOS-i] : giro[i])
        destino = ANCHO'((int'(bus.indice) + (bus.dir ? NUM_CUBOS - i : i)) % NUM_CUBOS);
  end
  assign siguiente = bus.cargar ? (carga_ok ? bus.valor_carga : bus.indice) : (paso ? destino : bus.indice);
  assign cruce = !bus.cargar && paso && |bus.habilitados &&
                 (bus.dir ? destino >= bus.indice : destino <= bus.indice);
  always_ff @(posedge clk)
    if (reset) begin
      bus.indice <= '0;
      bus.activaciones_cubos <= NUM_CUBOS'(1);
      bus.vuelta <= 1'b0;
      bus.ninguno <= 1'b0;
    end else begin
      bus.indice <= siguiente;
      bus.activaciones_cubos <= NUM_CUBOS'(1) << siguiente;
      bus.vuelta <= cruce;
      bus.ninguno <= ~|bus.habilitados;
    end
endmodule
